// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide execute unit with pipeline hold and a one-cycle write pulse.
// Optional `MULDIV_FAST_MUL_EN`: single-cycle combinational multiply; division stays iterative.
module ex_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_wen_o,
    output logic            hold_flag_o,
    output logic            busy_o
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic              rd_wen_q, rd_wen_d;
    logic              busy_q, busy_d;

    op_e               op_sel;
    logic              a_sgn, b_sgn, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   fast_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step_next;

    // Multiply: full = magnitude product. Divide: full = {remainder, quotient}.
    function automatic logic [XLEN-1:0] pick_result(input logic [2:0] op, input logic neg,
                                                    input logic [2*XLEN-1:0] full);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   dv;
        prod = neg ? -full : full;
        dv   = op[1] ? full[2*XLEN-1:XLEN] : full[XLEN-1:0];
        if (neg) dv = -dv;
        if (op[2])                return dv;
        else if (op[1:0] == 2'b00) return prod[XLEN-1:0];
        else                      return prod[2*XLEN-1:XLEN];
    endfunction

    assign op_sel = op_e'(op_i);
    assign a_sgn  = rs1_data_i[XLEN-1] &
                    (op_sel == OP_MULH || op_sel == OP_MULHSU || op_sel == OP_DIV || op_sel == OP_REM);
    assign b_sgn  = rs2_data_i[XLEN-1] &
                    (op_sel == OP_MULH || op_sel == OP_DIV || op_sel == OP_REM);
    assign a_mag  = a_sgn ? -rs1_data_i : rs1_data_i;
    assign b_mag  = b_sgn ? -rs2_data_i : rs2_data_i;
    // Remainder sign follows the dividend; everything else is the product of operand signs.
    assign neg_in = (op_i[2:1] == 2'b11) ? a_sgn : (a_sgn ^ b_sgn);

    assign div_zero = op_i[2] & (rs2_data_i == '0);
    assign div_ovf  = op_i[2] & ~op_i[0] & (rs1_data_i == MIN_NEG) & (rs2_data_i == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign fast      = div_zero | div_ovf | ~op_i[2];
    always_comb begin
        if (!op_i[2])     fast_res = pick_result(op_i, neg_in, fast_prod);
        else if (div_zero) fast_res = op_i[1] ? rs1_data_i : '1;
        else              fast_res = op_i[1] ? '0 : rs1_data_i;
    end
`else
    assign fast = div_zero | div_ovf;
    always_comb begin
        if (div_zero) fast_res = op_i[1] ? rs1_data_i : '1;
        else          fast_res = op_i[1] ? '0 : rs1_data_i;
    end
`endif

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

    // Restoring divide: shift {rem, quot} left, subtract divisor if it fits.
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

    assign step_next = op_q[2] ? div_next : mul_next;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_d     = neg_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        rd_wen_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    op_d      = op_i;
                    neg_d     = neg_in;
                    b_d       = b_mag;
                    acc_d     = {{XLEN{1'b0}}, a_mag};
                    cnt_d     = '0;
                    rd_addr_d = rd_addr_i;
                    if (fast) begin
                        state_d   = DONE;
                        rd_data_d = fast_res;
                        rd_wen_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d   = DONE;
                    rd_data_d = pick_result(op_q, neg_q, step_next);
                    rd_wen_d  = 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                rd_data_d = '0;
                rd_addr_d = '0;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i && state_q != IDLE) begin
            state_d   = IDLE;
            rd_wen_d  = 1'b0;
            rd_data_d = '0;
            rd_addr_d = '0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            rd_wen_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            rd_wen_q  <= rd_wen_d;
            busy_q    <= busy_d;
        end
    end

    assign hold_flag_o = ~rst & (((state_q == IDLE) & start_i & ~flush_i) | (state_q == CALC));
    assign rd_addr_o   = rd_addr_q;
    assign rd_data_o   = rd_data_q;
    assign rd_wen_o    = rd_wen_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (XLEN=32) against an arithmetic reference model.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o;
    logic        hold_flag_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .rd_wen_o(rd_wen_o), .hold_flag_o(hold_flag_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 33;
    endfunction

    // Drives one request and observes it; handshake_ok covers hold/busy/zero-data shape.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output int lat, output logic [31:0] data, output logic [4:0] addr, output bit handshake_ok);
        handshake_ok = 1'b1;
        @(negedge clk);
        start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
        #1;
        if (hold_flag_o !== 1'b1 || rd_wen_o !== 1'b0) handshake_ok = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 1;
        while (rd_wen_o !== 1'b1 && lat < 100) begin
            if (hold_flag_o !== 1'b1 || rd_data_o !== '0 || busy_o !== 1'b1) handshake_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        data = rd_data_o;
        addr = rd_addr_o;
        if (hold_flag_o !== 1'b0 || busy_o !== 1'b1) handshake_ok = 1'b0;
        @(posedge clk); #1;
        if (rd_wen_o !== 1'b0 || busy_o !== 1'b0 || rd_data_o !== '0) handshake_ok = 1'b0;
    endtask

    task automatic test_reset();
        start_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0h data=%0h wen=%b hold=%b busy=%b, need all 0",
                     rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o, busy_o);
        end
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || hold_flag_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b hold=%b, need 0 0", busy_o, hold_flag_o);
        end
    endtask

    task automatic test_mul();
        int lat; logic [31:0] d; logic [4:0] ad; bit ok;
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd17, lat, d, ad, ok);
        checks++;
        if (d !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_data: got %h need ffffffeb", d); end
        checks++;
        if (lat !== exp_lat(3'd0, 32'd7, 32'hFFFF_FFFD)) begin
            errors++; $display("FAIL mul_latency: got %0d need %0d", lat, exp_lat(3'd0, 32'd7, 32'hFFFF_FFFD));
        end
        checks++;
        if (ad !== 5'd17) begin errors++; $display("FAIL mul_rd_addr: got %0d need 17", ad); end
        checks++;
        if (!ok) begin errors++; $display("FAIL mul_handshake: got hold/busy/data shape wrong, need hold through CALC"); end
    endtask

    task automatic test_mulh();
        logic [2:0]  ops  [3] = '{3'd3, 3'd1, 3'd2};
        logic [31:0] want [3] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF};
        int lat; logic [31:0] d; logic [4:0] ad; bit ok;
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, lat, d, ad, ok);
            checks++;
            if (d !== want[i] || lat !== exp_lat(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF)) begin
                errors++;
                $display("FAIL mulh_op%0d: got data=%h lat=%0d need data=%h lat=%0d",
                         ops[i], d, lat, want[i], exp_lat(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF));
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] want [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int lat; logic [31:0] d; logic [4:0] ad; bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], 5'd2, lat, d, ad, ok);
            checks++;
            if (d !== want[i] || lat !== 33 || !ok) begin
                errors++;
                $display("FAIL div_op%0d: got data=%h lat=%0d ok=%b need data=%h lat=33 ok=1", ops[i], d, lat, ok, want[i]);
            end
        end
    endtask

    task automatic test_fast_div();
        logic [2:0]  ops  [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] as   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] want [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int lat; logic [31:0] d; logic [4:0] ad; bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], 5'd30, lat, d, ad, ok);
            checks++;
            if (d !== want[i] || lat !== 1 || ad !== 5'd30 || !ok) begin
                errors++;
                $display("FAIL fastdiv_%0d: got data=%h lat=%0d addr=%0d need data=%h lat=1 addr=30", i, d, lat, ad, want[i]);
            end
        end
    endtask

    task automatic test_flush();
        int lat; logic [31:0] d; logic [4:0] ad; bit ok;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd5; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; rd_addr_i = 5'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        checks++;
        if (busy_o !== 1'b1 || hold_flag_o !== 1'b1) begin
            errors++; $display("FAIL flush_pre: got busy=%b hold=%b need 1 1", busy_o, hold_flag_o);
        end
        @(posedge clk); #1;
        flush_i = 1'b0;
        checks++;
        if ({rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL flush_post: got addr=%0d data=%h wen=%b hold=%b busy=%b need all 0",
                     rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o, busy_o);
        end
        do_op(3'd6, 32'hFFFF_FF00, 32'd7, 5'd11, lat, d, ad, ok);
        checks++;
        if (d !== ref_result(3'd6, 32'hFFFF_FF00, 32'd7) || lat !== 33 || ad !== 5'd11 || !ok) begin
            errors++;
            $display("FAIL flush_restart: got data=%h lat=%0d addr=%0d ok=%b need data=%h lat=33 addr=11",
                     d, lat, ad, ok, ref_result(3'd6, 32'hFFFF_FF00, 32'd7));
        end
    endtask

    task automatic test_rst_mid();
        int lat; logic [31:0] d; logic [4:0] ad; bit ok;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd7; rs1_data_i = 32'd12345; rs2_data_i = 32'd77; rd_addr_i = 5'd9;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        start_i = 1'b1;
        #1;
        checks++;
        if ({rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: got addr=%0d data=%h wen=%b hold=%b busy=%b need all 0",
                     rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o, busy_o);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || hold_flag_o !== 1'b0 || rd_wen_o !== 1'b0) begin
            errors++; $display("FAIL rst_hold_start: got busy=%b hold=%b wen=%b need 0 0 0", busy_o, hold_flag_o, rd_wen_o);
        end
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        do_op(3'd7, 32'd12345, 32'd77, 5'd9, lat, d, ad, ok);
        checks++;
        if (d !== 32'd25 || lat !== 33 || !ok) begin
            errors++; $display("FAIL rst_then_op: got data=%h lat=%0d ok=%b need data=19 lat=33", d, lat, ok);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] d; logic [4:0] ad; bit ok;
        logic [2:0] op; logic [31:0] a, b; logic [4:0] rd;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                default: ;
            endcase
            do_op(op, a, b, rd, lat, d, ad, ok);
            checks++;
            if (d !== ref_result(op, a, b) || lat !== exp_lat(op, a, b) || ad !== rd || !ok) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got data=%h lat=%0d addr=%0d ok=%b need data=%h lat=%0d addr=%0d",
                         i, op, a, b, d, lat, ad, ok, ref_result(op, a, b), exp_lat(op, a, b), rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_fast_div();
        test_flush();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
